// File: rtl/expr_pkg.sv
// Shared encodings for the ASCII expression emitter: character constants,
// FSM states, operator encoding and character helpers.
package expr_pkg;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    OP    = 2'd2
  } state_e;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return CH_ZERO + {4'h0, d};
  endfunction

  function automatic logic [7:0] op_char(input logic op);
    return (op == OP_MUL) ? CH_STAR : CH_PLUS;
  endfunction

endpackage

// File: rtl/expr_cfg_check.sv
// Combinational validator: operand count in range and every used term a BCD digit.
module expr_cfg_check #(
  parameter int MAX_TERMS = 8,
  parameter int CW        = $clog2(MAX_TERMS) + 1
) (
  input  logic [CW-1:0]          nterms_i,
  input  logic [4*MAX_TERMS-1:0] digits_i,
  output logic                   cfg_ok_o
);

  always_comb begin
    cfg_ok_o = (nterms_i != '0) && (nterms_i <= CW'(MAX_TERMS));
    // Terms beyond nterms are don't-care and may hold any nibble.
    for (int i = 0; i < MAX_TERMS; i++) begin
      if ((CW'(i) < nterms_i) && (digits_i[4*i +: 4] > 4'd9)) begin
        cfg_ok_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/expr_emitter.sv
// Emits a latched expression digit ((+|*) digit)* as one ASCII byte per
// valid/ready handshake; all outputs are registered.
module expr_emitter
  import expr_pkg::*;
#(
  parameter int MAX_TERMS = 8,
  parameter int CW        = $clog2(MAX_TERMS) + 1
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [CW-1:0]          nterms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  output logic [7:0]             out_char,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_e                 state_q, state_d;
  logic [CW-1:0]          idx_q, idx_d, nterms_q, nterms_d;
  logic [4*MAX_TERMS-1:0] digits_q, digits_d;
  logic [MAX_TERMS-2:0]   ops_q, ops_d;
  logic [7:0]             char_q, char_d;
  logic                   valid_q, valid_d, busy_q, busy_d;
  logic                   done_q, done_d, err_q, err_d;
  logic                   cfg_ok, hs, last;

  function automatic logic [3:0] pick_digit(input logic [4*MAX_TERMS-1:0] d,
                                            input logic [CW-1:0] i);
    pick_digit = '0;
    for (int k = 0; k < MAX_TERMS; k++) begin
      if (i == CW'(k)) pick_digit = d[4*k +: 4];
    end
  endfunction

  function automatic logic pick_op(input logic [MAX_TERMS-2:0] o,
                                   input logic [CW-1:0] i);
    pick_op = OP_ADD;
    for (int k = 0; k < MAX_TERMS - 1; k++) begin
      if (i == CW'(k)) pick_op = o[k];
    end
  endfunction

  expr_cfg_check #(
    .MAX_TERMS(MAX_TERMS),
    .CW       (CW)
  ) u_cfg_check (
    .nterms_i(nterms),
    .digits_i(digits),
    .cfg_ok_o(cfg_ok)
  );

  assign hs   = valid_q & out_ready;
  assign last = (idx_q == nterms_q - CW'(1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    nterms_d = nterms_q;
    digits_d = digits_q;
    ops_d    = ops_q;
    char_d   = char_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            nterms_d = nterms;
            digits_d = digits;
            ops_d    = ops;
            idx_d    = '0;
            char_d   = digit_char(digits[3:0]);
            valid_d  = 1'b1;
            busy_d   = 1'b1;
            state_d  = DIGIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DIGIT: begin
        // Operators are only read while idx < nterms-1, so unused ops bits stay untouched.
        if (hs) begin
          if (last) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            char_d  = op_char(pick_op(ops_q, idx_q));
            state_d = OP;
          end
        end
      end
      OP: begin
        if (hs) begin
          idx_d   = idx_q + CW'(1);
          char_d  = digit_char(pick_digit(digits_q, idx_q + CW'(1)));
          state_d = DIGIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      nterms_q <= '0;
      digits_q <= '0;
      ops_q    <= '0;
      char_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      nterms_q <= nterms_d;
      digits_q <= digits_d;
      ops_q    <= ops_d;
      char_q   <= char_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign out_char  = char_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_expr_emitter.sv
// Bench for expr_emitter: a byte-queue model of the expected stream checked
// every cycle, directed literal cases, and randomized expressions with backpressure.
module tb_expr_emitter;

  localparam int MAX_TERMS = 8;
  localparam int CW        = 4;

  logic                   clk = 1'b0;
  logic                   clr = 1'b1;
  logic                   start = 1'b0;
  logic [CW-1:0]          nterms = '0;
  logic [4*MAX_TERMS-1:0] digits = '0;
  logic [MAX_TERMS-2:0]   ops = '0;
  logic                   out_ready = 1'b0;
  logic [7:0]             out_char;
  logic                   out_valid, busy, done, err;

  expr_emitter #(.MAX_TERMS(MAX_TERMS), .CW(CW)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .nterms   (nterms),
    .digits   (digits),
    .ops      (ops),
    .out_char (out_char),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  bit         m_busy = 0, exp_done = 0, exp_err = 0, lb_digit = 1;
  logic [7:0] hs_byte[$];
  int         hs_cyc[$];
  int         done_cyc[$];
  int         err_cyc[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic bit cfg_valid(input int n, input logic [31:0] d);
    if (n < 1 || n > MAX_TERMS) return 0;
    for (int i = 0; i < n; i++) if (d[4*i +: 4] > 4'd9) return 0;
    return 1;
  endfunction

  // Expected text of an expression: digit, then (op, digit) pairs.
  task automatic build_expr(input int n, input logic [31:0] d, input logic [6:0] o);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(8'h30 + {4'h0, d[4*i +: 4]});
      if (i < n - 1) exp_q.push_back(o[i] ? 8'h2A : 8'h2B);
    end
  endtask

  // Model/compare process: outputs checked on every falling edge.
  always @(negedge clk) begin
    if (clr) begin
      chk("rst_out_char", 32'(out_char), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      exp_q.delete();
      m_busy = 0; exp_done = 0; exp_err = 0;
    end else begin
      chk("done", 32'(done), 32'(exp_done));
      chk("err", 32'(err), 32'(exp_err));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("out_valid", 32'(out_valid), 32'(m_busy));
      if (done) done_cyc.push_back(cyc);
      if (err) err_cyc.push_back(cyc);
      exp_done = 0;
      exp_err  = 0;
      if (m_busy) begin
        chk("out_char", 32'(out_char), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'hFFFF);
        if (out_ready) begin
          hs_byte.push_back(out_char);
          hs_cyc.push_back(cyc);
          if (lb_digit) chk("loopback_digit", 32'(out_char >= 8'h30 && out_char <= 8'h39), 32'h1);
          else          chk("loopback_op", 32'(out_char == 8'h2A || out_char == 8'h2B), 32'h1);
          lb_digit = !lb_digit;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            chk("loopback_ends_on_digit", 32'(lb_digit), 32'h0);
            m_busy   = 0;
            exp_done = 1;
          end
        end
      end else if (start) begin
        if (cfg_valid(int'(nterms), digits)) begin
          build_expr(int'(nterms), digits, ops);
          m_busy   = 1;
          lb_digit = 1;
        end else begin
          exp_err = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    hs_byte.delete(); hs_cyc.delete(); done_cyc.delete(); err_cyc.delete();
  endtask

  // One-cycle start; inputs are scrambled afterwards since the DUT must have latched them.
  task automatic pulse_start(input int n, input logic [31:0] d, input logic [6:0] o, output int sc);
    nterms = CW'(n); digits = d; ops = o; start = 1'b1; sc = cyc;
    tick();
    start  = 1'b0;
    nterms = CW'($urandom_range(0, 15));
    digits = $urandom;
    ops    = 7'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy && !out_valid && !m_busy) break;
    end
    n_cmp++;
    if (k >= 400) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d cycles, expected fewer than 400", name, k);
    end
    tick();
  endtask

  logic [7:0] basic_lit[5] = '{8'h31, 8'h2B, 8'h32, 8'h2A, 8'h33};
  int         bp_off[5]    = '{1, 5, 6, 7, 8};

  initial begin
    int sc, k;
    clr = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    chk("reset_char_literal", 32'(out_char), 32'h0);
    chk("reset_busy_literal", 32'(busy), 32'h0);
    clr = 1'b0;
    tick();

    // Basic stream 1+2*3
    clear_cap();
    pulse_start(3, 32'h321, 7'b0000010, sc);
    wait_idle("basic");
    chk("basic_count", 32'(hs_byte.size()), 32'd5);
    for (int i = 0; i < 5; i++) if (i < hs_byte.size()) begin
      chk("basic_byte", 32'(hs_byte[i]), 32'(basic_lit[i]));
      chk("basic_byte_cycle", 32'(hs_cyc[i] - sc), 32'(i + 1));
    end
    chk("basic_done_count", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0) chk("basic_done_cycle", 32'(done_cyc[0] - sc), 32'd6);
    chk("basic_busy_after", 32'(busy), 32'h0);

    // Single term
    clear_cap();
    pulse_start(1, 32'h9, 7'b1111111, sc);
    wait_idle("single");
    chk("single_count", 32'(hs_byte.size()), 32'd1);
    if (hs_byte.size() > 0) chk("single_byte", 32'(hs_byte[0]), 32'h39);
    if (done_cyc.size() > 0) chk("single_done_cycle", 32'(done_cyc[0] - sc), 32'd2);

    // Backpressure on byte 2
    clear_cap();
    pulse_start(3, 32'h321, 7'b0000010, sc);
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    wait_idle("backpressure");
    chk("bp_count", 32'(hs_byte.size()), 32'd5);
    for (int i = 0; i < 5; i++) if (i < hs_byte.size()) begin
      chk("bp_byte", 32'(hs_byte[i]), 32'(basic_lit[i]));
      chk("bp_byte_cycle", 32'(hs_cyc[i] - sc), 32'(bp_off[i]));
    end
    if (done_cyc.size() > 0) chk("bp_done_cycle", 32'(done_cyc[0] - sc), 32'd9);

    // Invalid requests: bad digit, nterms 0, nterms above max
    clear_cap();
    pulse_start(2, 32'hA3, 7'b0, sc);
    repeat (2) tick();
    chk("bad_digit_err_count", 32'(err_cyc.size()), 32'd1);
    if (err_cyc.size() > 0) chk("bad_digit_err_cycle", 32'(err_cyc[0] - sc), 32'd1);
    chk("bad_digit_no_bytes", 32'(hs_byte.size()), 32'd0);
    clear_cap();
    pulse_start(0, 32'h1, 7'b0, sc);
    repeat (2) tick();
    chk("nterms0_err_count", 32'(err_cyc.size()), 32'd1);
    clear_cap();
    pulse_start(9, 32'h1, 7'b0, sc);
    repeat (2) tick();
    chk("nterms9_err_count", 32'(err_cyc.size()), 32'd1);

    // Unused terms may hold non-BCD nibbles; full-length expression
    clear_cap();
    pulse_start(1, 32'hFFFFFFF5, 7'b0, sc);
    wait_idle("unused_terms");
    chk("unused_terms_err", 32'(err_cyc.size()), 32'd0);
    if (hs_byte.size() > 0) chk("unused_terms_byte", 32'(hs_byte[0]), 32'h35);
    clear_cap();
    pulse_start(8, 32'h98765432, 7'b1010101, sc);
    wait_idle("max_terms");
    chk("max_terms_count", 32'(hs_byte.size()), 32'd15);
    if (hs_byte.size() == 15) chk("max_terms_last", 32'(hs_byte[14]), 32'h39);

    // clr mid-stream
    clear_cap();
    pulse_start(3, 32'h321, 7'b0000010, sc);
    repeat (2) tick();
    clr = 1'b1;
    #1;
    chk("clr_immediate_valid", 32'(out_valid), 32'h0);
    chk("clr_immediate_busy", 32'(busy), 32'h0);
    repeat (2) tick();
    clr = 1'b0;
    repeat (3) tick();
    chk("clr_bytes_before", 32'(hs_byte.size()), 32'd2);
    chk("clr_no_done", 32'(done_cyc.size()), 32'd0);
    clear_cap();
    pulse_start(3, 32'h321, 7'b0000010, sc);
    wait_idle("after_clr");
    chk("after_clr_count", 32'(hs_byte.size()), 32'd5);
    if (hs_byte.size() > 0) chk("after_clr_first", 32'(hs_byte[0]), 32'h31);

    // start while busy is ignored
    clear_cap();
    pulse_start(3, 32'h321, 7'b0000010, sc);
    nterms = '0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("busy_start");
    chk("busy_start_no_err", 32'(err_cyc.size()), 32'd0);
    chk("busy_start_count", 32'(hs_byte.size()), 32'd5);
    for (int i = 0; i < 5; i++) if (i < hs_byte.size())
      chk("busy_start_byte", 32'(hs_byte[i]), 32'(basic_lit[i]));

    // start held across done: second stream starts after the done cycle
    clear_cap();
    nterms = CW'(2); digits = 32'h54; ops = 7'b1; start = 1'b1;
    repeat (8) tick();
    start = 1'b0;
    wait_idle("held_start");
    chk("held_count", 32'(hs_byte.size()), 32'd6);
    chk("held_done_count", 32'(done_cyc.size()), 32'd2);
    if (done_cyc.size() == 2) chk("held_done_gap", 32'(done_cyc[1] - done_cyc[0]), 32'd4);
    if (hs_byte.size() == 6) chk("held_restart_byte", 32'(hs_byte[3]), 32'h34);

    // Randomized expressions with random backpressure and stray starts
    for (int e = 0; e < 200; e++) begin
      int n;
      logic [31:0] d;
      n = $urandom_range(1, MAX_TERMS);
      d = '0;
      for (int i = 0; i < MAX_TERMS; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) begin
        n = $urandom_range(0, 15);
        d = $urandom;
      end
      out_ready = 1'b1;
      pulse_start(n, d, 7'($urandom), sc);
      for (k = 0; k < 300; k++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 15) == 0);
        tick();
        start = 1'b0;
        if (!busy && !m_busy) break;
      end
      n_cmp++;
      if (k >= 300) begin
        n_bad++;
        $display("FAIL random_timeout: got %0d cycles, expected fewer than 300", k);
      end
      tick();
    end
    out_ready = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected completion before 5 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
